// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit sequencer state encoding and byte width.
// Imported by tx_control and tx_timeout_cnt; the receive side can reuse the same constants.
// No ports; package only.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    WAIT_DONE,
    FINISH
  } tx_state_t;

endpackage

// File: rtl/tx_timeout_cnt.sv
// Handshake timeout counter: cleared by load, counts while en is high, flags expire at LIMIT-1.
// Ports: clk, reset (async, active-low), load (clear to 0), en (count), expire (cnt == LIMIT-1).
// The count saturates at LIMIT-1 so a stalled owner never sees the flag drop back.
module tx_timeout_cnt
  import uart_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] cnt;

  assign expire = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tx_control.sv
// Result transmit sequencer: captures an N_BYTES result on tx_trigger and feeds it LSB byte first
// to uart_tx using the tx_start/tx_busy handshake; reports busy, done and ack-timeout error.
// Ports: clk, reset (async active-low), tx_trigger, result_data, tx_busy in; tx_start, tx_data,
// busy, done, error out (all registered). Triggers arriving while busy are dropped, not queued.
module tx_control
  import uart_pkg::*;
#(
  parameter int N_BYTES     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_trigger,
  input  logic [N_BYTES*BYTE_W-1:0] result_data,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int DW  = N_BYTES * BYTE_W;
  localparam int BCW = $clog2(N_BYTES) + 1;

  tx_state_t        state, state_nxt;
  logic [DW-1:0]    shreg;
  logic [BCW-1:0]   byte_cnt;
  logic             last_byte;
  logic             shreg_ld, shreg_shift;
  logic             to_load, to_en, to_expire;
  logic             err_set;

  assign last_byte = (byte_cnt == BCW'(N_BYTES - 1));

  tx_timeout_cnt #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (to_load),
    .en     (to_en),
    .expire (to_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_ld    = 1'b0;
    shreg_shift = 1'b0;
    to_load     = 1'b0;
    to_en       = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_trigger) begin
          state_nxt = LOAD;
          shreg_ld  = 1'b1;
        end
      end
      LOAD: begin
        state_nxt = WAIT_ACK;
        to_load   = 1'b1;
      end
      WAIT_ACK: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_expire) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end else begin
          to_en = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_byte) begin
            state_nxt = FINISH;
          end else begin
            state_nxt   = LOAD;
            shreg_shift = 1'b1;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so that busy tracks the state exactly,
  // done coincides with the single FINISH cycle, and error lands on the first IDLE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      tx_start <= (state == LOAD);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FINISH);
      error    <= err_set;
      // tx_data only changes in LOAD, so it stays put for the whole frame.
      if (state == LOAD) begin
        tx_data <= shreg[BYTE_W-1:0];
      end
      if (shreg_ld) begin
        shreg    <= result_data;
        byte_cnt <= '0;
      end else if (shreg_shift) begin
        shreg    <= shreg >> BYTE_W;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_control.sv
module tb_tx_control;

  localparam int NB     = 2;
  localparam int ACK_TO = 16;
  localparam int HMAX   = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_trigger;
  logic [15:0] result_data;
  logic        mdl_busy, hold_busy;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy, done, error;

  logic        trig1, busy1, start1, bsy1, done1, err1;
  logic [7:0]  res1, data1;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   uart_ack_dly = 1;
  int   uart_len = 1;
  bit   uart_noack = 1'b0;
  logic busy_h [0:HMAX-1];

  logic [7:0] st_d[$];
  int         st_t[$];
  int         dn_t[$];
  int         er_t[$];

  typedef struct {
    logic [15:0] v;
    int          a;
    int          l;
    bit          noack;
    int          rt;
    int          hold;
    int          es;
    int          ed;
    int          ee;
  } vec_t;

  vec_t tbl[7];

  assign tx_busy = mdl_busy | hold_busy;

  tx_control #(.N_BYTES(NB), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .tx_trigger(tx_trigger), .result_data(result_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .done(done), .error(error)
  );

  tx_control #(.N_BYTES(1), .ACK_TIMEOUT(ACK_TO)) dut1 (
    .clk(clk), .reset(reset), .tx_trigger(trig1), .result_data(res1),
    .tx_busy(busy1), .tx_start(start1), .tx_data(data1), .busy(bsy1),
    .done(done1), .error(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: every output observation happens at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < HMAX) busy_h[cyc] = busy;
      if (tx_start) begin
        st_d.push_back(tx_data);
        st_t.push_back(cyc);
      end
      if (done) dn_t.push_back(cyc);
      if (error) er_t.push_back(cyc);
    end
  end

  // UART transmitter model: busy rises uart_ack_dly cycles after tx_start, lasts uart_len cycles.
  initial begin
    mdl_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !uart_noack && reset) begin
        repeat (uart_ack_dly) @(negedge clk);
        mdl_busy = 1'b1;
        repeat (uart_len) @(negedge clk);
        mdl_busy = 1'b0;
      end
    end
  end

  function automatic logic bh(input int c);
    if (c >= 0 && c < HMAX) return busy_h[c];
    return 1'bx;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    st_d.delete();
    st_t.delete();
    dn_t.delete();
    er_t.delete();
  endtask

  // One transfer with an 80-cycle observation window, checked against a timeline derived
  // directly from the handshake rules: start at trigger+2, next start 2 cycles after busy
  // falls, done 1 cycle after the last fall, error ACK_TO cycles after an unanswered start.
  task automatic run_xfer(input logic [15:0] v, input int a, input int l, input bit noack,
                          input int rt, input int hold, input int es, input int ed, input int ee);
    int t, s, f, exp_done, exp_err;
    int exp_t[$];
    logic [7:0] exp_d[$];
    @(negedge clk);
    uart_ack_dly = a;
    uart_len     = l;
    uart_noack   = noack;
    clear_log();
    t = cyc;
    tx_trigger  = 1'b1;
    result_data = v;
    hold_busy   = (hold > 0);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      tx_trigger = (k == rt);
      if (k == rt) result_data = 16'h1234;
      hold_busy = (k < hold);
    end
    tx_trigger = 1'b0;

    exp_done = -1;
    exp_err  = -1;
    s = t + 2;
    for (int i = 0; i < NB; i++) begin
      exp_t.push_back(s);
      exp_d.push_back(v[8*i +: 8]);
      if (noack || a >= ACK_TO) begin
        exp_err = s + ACK_TO;
        break;
      end
      f = s + a + l;
      if (i == 0 && t + hold > f) f = t + hold;
      if (i == NB - 1) exp_done = f + 1;
      else s = f + 2;
    end

    chk("n_start", st_d.size(), es);
    chk("n_done", dn_t.size(), ed);
    chk("n_error", er_t.size(), ee);
    chk("busy_trig_cyc", bh(t), 1'b0);
    chk("busy_after_trig", bh(t + 1), 1'b1);
    for (int i = 0; i < exp_t.size(); i++) begin
      if (i < st_d.size()) begin
        chk("byte_data", st_d[i], exp_d[i]);
        chk("start_cyc", st_t[i] - t, exp_t[i] - t);
      end
    end
    if (exp_done >= 0 && dn_t.size() > 0) begin
      chk("done_cyc", dn_t[0] - t, exp_done - t);
      chk("busy_at_done", bh(exp_done), 1'b1);
      chk("busy_after_done", bh(exp_done + 1), 1'b0);
    end
    if (exp_err >= 0 && er_t.size() > 0) begin
      chk("error_cyc", er_t[0] - t, exp_err - t);
      chk("busy_at_error", bh(exp_err), 1'b0);
      chk("busy_before_error", bh(exp_err - 1), 1'b1);
    end
  endtask

  initial begin
    int t, d, ns1, nd1, st1, dt1;
    logic anyb, fire, anyerr1;
    logic [7:0] sd1;
    logic [7:0] exp4 [4];
    logic [15:0] rv;
    int ra, rl, rrt;
    bit rna;

    reset = 1'b0;
    tx_trigger = 1'b0;
    result_data = '0;
    hold_busy = 1'b0;
    trig1 = 1'b0;
    res1 = '0;
    busy1 = 1'b0;

    //          v         a   l   noack rt hold es ed ee
    tbl[0] = '{16'hA55A,  1, 10, 1'b0, 0, 0,   2, 1, 0};
    tbl[1] = '{16'hBEEF,  1, 10, 1'b0, 5, 0,   2, 1, 0};
    tbl[2] = '{16'h0F0F,  0,  1, 1'b0, 0, 0,   2, 1, 0};
    tbl[3] = '{16'hFFFF, 15,  3, 1'b0, 0, 0,   2, 1, 0};
    tbl[4] = '{16'h1357, 16,  3, 1'b0, 0, 0,   1, 0, 1};
    tbl[5] = '{16'h2468,  0,  0, 1'b1, 0, 0,   1, 0, 1};
    tbl[6] = '{16'hC0DE,  1,  4, 1'b0, 0, 5,   2, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_n1_busy", bsy1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_xfer(tbl[i].v, tbl[i].a, tbl[i].l, tbl[i].noack, tbl[i].rt, tbl[i].hold,
               tbl[i].es, tbl[i].ed, tbl[i].ee);
    end

    // Trigger coincident with reset is discarded.
    @(negedge clk);
    clear_log();
    reset = 1'b0;
    tx_trigger = 1'b1;
    result_data = 16'h5555;
    @(negedge clk);
    reset = 1'b1;
    tx_trigger = 1'b0;
    anyb = 1'b0;
    repeat (8) begin
      @(negedge clk);
      anyb |= busy;
    end
    chk("trig_rst_busy", anyb, 1'b0);
    chk("trig_rst_start", st_d.size(), 0);

    // Reset in WAIT_DONE of byte 0 clears outputs without a clock edge.
    @(negedge clk);
    uart_ack_dly = 1;
    uart_len = 10;
    uart_noack = 1'b0;
    t = cyc;
    tx_trigger = 1'b1;
    result_data = 16'h6789;
    @(negedge clk);
    tx_trigger = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_pre_busy", busy, 1'b1);
    chk("midrst_pre_data", tx_data, 8'h89);
    reset = 1'b0;
    #1;
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_tx_start", tx_start, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    run_xfer(16'h4321, 1, 6, 1'b0, 0, 0, 2, 1, 0);

    // Back-to-back: retrigger on the cycle after done.
    @(negedge clk);
    uart_ack_dly = 1;
    uart_len = 3;
    uart_noack = 1'b0;
    clear_log();
    tx_trigger = 1'b1;
    result_data = 16'h9A8B;
    d = -1;
    fire = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      tx_trigger = 1'b0;
      if (fire) begin
        tx_trigger = 1'b1;
        result_data = 16'h7C6D;
        fire = 1'b0;
      end
      if (done && d < 0) begin
        d = cyc;
        fire = 1'b1;
      end
    end
    exp4[0] = 8'h8B;
    exp4[1] = 8'h9A;
    exp4[2] = 8'h6D;
    exp4[3] = 8'h7C;
    chk("b2b_n_start", st_d.size(), 4);
    chk("b2b_n_done", dn_t.size(), 2);
    for (int i = 0; i < 4; i++) begin
      if (i < st_d.size()) chk("b2b_byte", st_d[i], exp4[i]);
    end
    if (d >= 0) begin
      chk("b2b_busy_done", bh(d), 1'b1);
      chk("b2b_busy_gap", bh(d + 1), 1'b0);
      chk("b2b_busy_resume", bh(d + 2), 1'b1);
    end else begin
      chk("b2b_done_seen", 1'b0, 1'b1);
    end

    // Single-byte build.
    @(negedge clk);
    trig1 = 1'b1;
    res1 = 8'hC3;
    t = cyc;
    ns1 = 0; nd1 = 0; st1 = -1; dt1 = -1; sd1 = '0; anyerr1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      trig1 = 1'b0;
      busy1 = (cyc >= t + 3 && cyc <= t + 6);
      if (start1) begin
        ns1++;
        st1 = cyc;
        sd1 = data1;
      end
      if (done1) begin
        nd1++;
        dt1 = cyc;
      end
      anyerr1 |= err1;
    end
    busy1 = 1'b0;
    chk("n1_n_start", ns1, 1);
    chk("n1_start_cyc", st1 - t, 2);
    chk("n1_data", sd1, 8'hC3);
    chk("n1_n_done", nd1, 1);
    chk("n1_done_cyc", dt1 - t, 8);
    chk("n1_error", anyerr1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rv  = 16'($urandom);
      ra  = int'($urandom_range(0, 4));
      rl  = int'($urandom_range(1, 12));
      rna = ($urandom_range(0, 7) == 0);
      rrt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0;
      run_xfer(rv, ra, rl, rna, rrt, 0, rna ? 1 : NB, rna ? 0 : 1, rna ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
